// File: rtl/morse_pkg.sv
// Shared Morse timing definitions.
// Used by the symbol sequencer and the character encoder.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MARK       = 3'd1,
        SPACE      = 3'd2,
        LETTER_GAP = 3'd3,
        WORD_GAP   = 3'd4
    } state_t;

    localparam int   CNT_W    = 4;
    localparam int   DOT_UNITS = 1;
    localparam int   SYM_UNITS = 1;
    localparam logic SYM_DASH = 1'b1;
    localparam logic SYM_DOT  = 1'b0;

    localparam int DEF_MAX_LEN          = 5;
    localparam int DEF_DASH_UNITS       = 3;
    localparam int DEF_LETTER_GAP_UNITS = 3;
    localparam int DEF_WORD_EXTRA_UNITS = 4;

    // Count value seen on the last tick of an n-unit element.
    function automatic logic [CNT_W-1:0] last_cnt(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Character handshake between the encoder and the sequencer.
// Encoder drives master, sequencer consumes as slave.
interface morse_symbol_sequencer_if #(
    parameter int MAX_LEN = morse_pkg::DEF_MAX_LEN
);
    logic               char_valid;
    logic               char_ready;
    logic [2:0]         char_len;
    logic [MAX_LEN-1:0] char_code;

    modport master (
        output char_valid,
        output char_len,
        output char_code,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_len,
        input  char_code,
        output char_ready
    );
endinterface

// File: rtl/morse_unit_counter.sv
// Unit counter measuring element lengths in unit ticks.
// Clear has priority over enable.
module morse_unit_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    // Count enabled ticks, cleared on reset or request.
    always_ff @(posedge CLK) begin
        if (RST || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/morse_symbol_sequencer.sv
// Keys one Morse character at a time, timing marks and gaps
// in unit ticks; len 0 requests an inter-word silence.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_LEN          = DEF_MAX_LEN,
    parameter int DASH_UNITS       = DEF_DASH_UNITS,
    parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
    parameter int WORD_EXTRA_UNITS = DEF_WORD_EXTRA_UNITS
) (
    input  logic CLK,
    input  logic RST,
    input  logic unit_tick,
    morse_symbol_sequencer_if.slave up,
    output logic key_out,
    output logic busy,
    output logic done
);
    localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [2:0]         len_q, len_d;
    logic [2:0]         idx_q, idx_d;
    logic               key_q, key_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   target;
    logic               cnt_clr;
    logic               accept;
    logic [2:0]         len_clamp;

    assign up.char_ready = (state_q == IDLE) && !RST;
    assign accept        = up.char_valid && up.char_ready;
    assign len_clamp     = (up.char_len > LEN_MAX) ? LEN_MAX : up.char_len;
    assign target        = (code_q[idx_q] == SYM_DASH)
                           ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);

    morse_unit_counter #(.W(CNT_W)) u_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (cnt_clr),
        .en_i    (unit_tick),
        .count_o (cnt)
    );

    // State, character and registered output storage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            code_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    // Next state: each element ends on the tick completing its length.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d  = up.char_code;
                    len_d   = len_clamp;
                    idx_d   = '0;
                    state_d = (len_clamp == 3'd0) ? WORD_GAP : MARK;
                end
            end
            MARK: begin
                if (unit_tick && cnt == target - CNT_W'(1)) begin
                    if (idx_q == len_q - 3'd1) begin
                        state_d = LETTER_GAP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (unit_tick && cnt == last_cnt(SYM_UNITS)) begin
                    state_d = MARK;
                end
            end
            LETTER_GAP: begin
                if (unit_tick && cnt == last_cnt(LETTER_GAP_UNITS)) begin
                    state_d = IDLE;
                end
            end
            WORD_GAP: begin
                if (unit_tick && cnt == last_cnt(WORD_EXTRA_UNITS)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and counter clear derived from the coming state.
    always_comb begin
        key_d   = (state_d == MARK);
        done_d  = (state_d == IDLE) &&
                  (state_q == LETTER_GAP || state_q == WORD_GAP);
        cnt_clr = (state_d != state_q) || (state_q == IDLE);
    end

    assign key_out = key_q && !RST;
    assign done    = done_q && !RST;
    assign busy    = (state_q != IDLE) && !RST;
endmodule
